// File: rtl/ptn_pkg.sv
// Shared definitions for the pattern player: default widths, RAM address width
// and the playback FSM state encoding.
package ptn_pkg;

    localparam int unsigned PTN_ADDR_W = 16;
    localparam int unsigned PTN_DATA_W = 16;
    localparam int unsigned RAM_ADDR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ptn_fifo2.sv
// Two-entry FIFO buffering RAM read data for the pattern stream.
// Flush is synchronous and overrides any push/pop in the same cycle.
module ptn_fifo2 #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              not_empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != 2'd0);

endmodule

// File: rtl/ptn_player.sv
// Pattern player: host access port to a single-port RAM in IDLE, and looped
// streaming of an address range out through a 2-entry FIFO during playback.
module ptn_player
    import ptn_pkg::*;
#(
    parameter int unsigned ADDR_W = PTN_ADDR_W,
    parameter int unsigned DATA_W = PTN_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic [DATA_W-1:0]     host_rdata,
    output logic                  host_rvalid,
    output logic                  host_err,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [ADDR_W-1:0]     end_addr,
    input  logic [7:0]            loop_cnt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     ptn_data,
    output logic                  ptn_valid,
    input  logic                  ptn_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [7:0]        passes;
    logic              inflight;
    logic              host_pend;
    logic              err_q;
    logic              done_q;
    logic              done_nx;
    logic              issue;
    logic              host_wr;
    logic              host_rd;
    logic              host_bad;
    logic              last_fetch;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [1:0]        fifo_count;
    logic [2:0]        level;

    assign host_wr    = !rst && (state == ST_IDLE) && host_we;
    assign host_rd    = !rst && (state == ST_IDLE) && host_re && !host_we;
    assign host_bad   = (state != ST_IDLE) ? (host_we || host_re) : (host_we && host_re);
    assign fifo_pop   = ptn_valid && ptn_ready;
    assign fifo_flush = abort && (state != ST_IDLE);
    assign last_fetch = (ptr == end_q) && (passes <= 8'd1);
    // Occupancy after this edge; counting the pop keeps 1 word/cycle with ready held high.
    assign level      = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, fifo_pop};

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        issue    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else begin
                    issue = (level < 3'd2);
                    if (issue && last_fetch) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!ptn_valid && !inflight) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (rst) issue = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            start_q     <= '0;
            end_q       <= '0;
            passes      <= '0;
            inflight    <= 1'b0;
            host_pend   <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            done_q      <= done_nx;
            inflight    <= issue;
            host_pend   <= host_rd;
            host_rvalid <= host_pend;
            if (host_pend) host_rdata <= ram_rdata;
            if (host_bad) err_q <= 1'b1;
            if (state == ST_IDLE && start) begin
                start_q <= start_addr;
                end_q   <= end_addr;
                ptr     <= start_addr;
                passes  <= (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
            end else if (issue) begin
                if (ptr == end_q) begin
                    if (passes > 8'd1) begin
                        ptr    <= start_q;
                        passes <= passes - 8'd1;
                    end
                end else begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        ram_en    = issue || host_wr || host_rd;
        ram_we    = host_wr;
        ram_addr  = '0;
        ram_wdata = '0;
        if (host_wr || host_rd) begin
            ram_addr = RAM_ADDR_W'(host_addr);
        end else if (issue) begin
            ram_addr = RAM_ADDR_W'(ptr);
        end
        if (host_wr) ram_wdata = host_wdata;
    end

    assign busy     = (state != ST_IDLE);
    assign done     = done_q;
    assign host_err = err_q;

    ptn_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (inflight),
        .push_data(ram_rdata),
        .pop      (fifo_pop),
        .head     (ptn_data),
        .not_empty(ptn_valid),
        .count    (fifo_count)
    );

endmodule
